// File: rtl/wbs_pkg.sv
// rtl/wbs_pkg.sv - shared types and constants for the writeback sequencer
//
// Purpose: result-mux select encoding, sequencer state encoding and the legal
// range of the bus-timeout parameter. Imported by wb_sequencer and
// wbs_timeout_ctr.
package wbs_pkg;

  // Result-mux select, as produced by the decoder and driven onto sel_o.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_PC4B = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } wbs_state_e;

  // Legal range for TIMEOUT_CYCLES; the counter is 8 bits wide.
  localparam int TIMEOUT_MIN = 2;
  localparam int TIMEOUT_MAX = 255;
  localparam int CTR_W       = 8;

endpackage

// File: rtl/wbs_timeout_ctr.sv
// rtl/wbs_timeout_ctr.sv - bus-timeout cycle counter for the writeback sequencer
//
// Purpose: counts cycles spent waiting for a grant or for load data. Only
// instantiated when WBS_TIMEOUT_EN is defined.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, counter to 0
//   clear_i - counter to 0 on the next edge (has priority over en_i)
//   en_i    - increment on the next edge
//   hit_o   - counter currently equals TIMEOUT_CYCLES-1
module wbs_timeout_ctr
  import wbs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic hit_o
);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CTR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - RV32I writeback sequencer with data-memory handshake
//
// Purpose: retires non-memory instructions in one cycle, stalls the core for
// loads/stores until the req/gnt/rvalid handshake completes, and drives the
// result-mux select and register-file write port. All outputs are
// combinational from the state register and the current inputs.
// Optional feature: define WBS_TIMEOUT_EN to build a bus-timeout counter that
// abandons an access after TIMEOUT_CYCLES cycles in REQ/WAIT and pulses fault_o.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   instr_valid_i           - decoded instruction present
//   result_src_i            - decoder result source (00 ALU, 01 MEM, 1x PC+4)
//   reg_write_i, rd_i       - instruction writes rd
//   mem_read_i, mem_write_i - load / store (both set means load)
//   dmem_req_o, dmem_gnt_i, dmem_rvalid_i - data-memory handshake
//   sel_o                   - result-mux select
//   rf_we_o, rf_waddr_o     - register-file write port
//   stall_o                 - hold PC and decode
//   fault_o                 - one-cycle bus-timeout pulse
module wb_sequencer
  import wbs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  input  logic [1:0] result_src_i,
  input  logic       reg_write_i,
  input  logic       mem_read_i,
  input  logic       mem_write_i,
  input  logic [4:0] rd_i,
  output logic       dmem_req_o,
  input  logic       dmem_gnt_i,
  input  logic       dmem_rvalid_i,
  output logic [1:0] sel_o,
  output logic       rf_we_o,
  output logic [4:0] rf_waddr_o,
  output logic       stall_o,
  output logic       fault_o
);

  if (TIMEOUT_CYCLES < TIMEOUT_MIN || TIMEOUT_CYCLES > TIMEOUT_MAX) begin : g_bad_timeout
    $error("wb_sequencer: TIMEOUT_CYCLES out of range 2..255");
  end

  wbs_state_e state_q, state_d;
  logic [4:0] rd_q, rd_d;
  logic       ld_q, ld_d;
  logic       timeout_hit;

`ifdef WBS_TIMEOUT_EN
  logic ctr_clear;

  // Restart the count whenever we are idle or about to change state, so it
  // measures time spent in the current REQ or WAIT visit only.
  assign ctr_clear = (state_q == IDLE) || (state_d != state_q);

  wbs_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(ctr_clear),
    .en_i   (!ctr_clear),
    .hit_o  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    ld_d       = ld_q;
    dmem_req_o = 1'b0;
    sel_o      = RES_ALU;
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    stall_o    = 1'b0;
    fault_o    = 1'b0;

    // While in reset every output stays at its default of 0.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            if (mem_read_i || mem_write_i) begin
              dmem_req_o = 1'b1;
              stall_o    = 1'b1;
              rd_d       = rd_i;
              ld_d       = mem_read_i;
              if (dmem_gnt_i) begin
                if (mem_read_i) begin
                  state_d = WAIT;
                end else begin
                  stall_o = 1'b0;  // store granted at once retires now
                end
              end else begin
                state_d = REQ;
              end
            end else begin
              sel_o      = result_src_i;
              rf_waddr_o = rd_i;
              rf_we_o    = reg_write_i && (rd_i != 5'd0);
            end
          end
        end

        REQ: begin
          dmem_req_o = 1'b1;
          stall_o    = 1'b1;
          if (dmem_gnt_i) begin
            if (ld_q) begin
              state_d = WAIT;
            end else begin
              stall_o = 1'b0;
              state_d = IDLE;
            end
          end else if (timeout_hit) begin
            dmem_req_o = 1'b0;
            stall_o    = 1'b0;
            fault_o    = 1'b1;
            state_d    = IDLE;
          end
        end

        WAIT: begin
          stall_o = 1'b1;
          if (dmem_rvalid_i) begin
            sel_o      = RES_MEM;
            rf_waddr_o = rd_q;
            rf_we_o    = (rd_q != 5'd0);
            stall_o    = 1'b0;
            state_d    = IDLE;
          end else if (timeout_hit) begin
            stall_o = 1'b0;
            fault_o = 1'b1;
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= '0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - self-checking bench for wb_sequencer
module tb_wb_sequencer;

  localparam int TO = 4;
`ifdef WBS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i, instr_valid_i, reg_write_i, mem_read_i, mem_write_i;
  logic [1:0] result_src_i;
  logic [4:0] rd_i;
  logic       dmem_req_o, dmem_gnt_i, dmem_rvalid_i;
  logic [1:0] sel_o;
  logic       rf_we_o;
  logic [4:0] rf_waddr_o;
  logic       stall_o, fault_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .instr_valid_i(instr_valid_i),
    .result_src_i (result_src_i),
    .reg_write_i  (reg_write_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .rd_i         (rd_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .sel_o        (sel_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .stall_o      (stall_o),
    .fault_o      (fault_o)
  );

  // Inputs: rst v src rw mr mw rd gnt rv. Expected: req sel we waddr stall fault.
  typedef struct {
    string      name;
    logic       rst, v;
    logic [1:0] src;
    logic       rw, mr, mw;
    logic [4:0] rd;
    logic       gnt, rv;
    logic       e_req;
    logic [1:0] e_sel;
    logic       e_we;
    logic [4:0] e_wa;
    logic       e_stall, e_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, v, input logic [1:0] src,
                     input logic rw, mr, mw, input logic [4:0] rd, input logic gnt, rv,
                     input logic e_req, input logic [1:0] e_sel, input logic e_we,
                     input logic [4:0] e_wa, input logic e_stall, e_fault);
    vec_t t;
    t.name = name; t.rst = rst; t.v = v; t.src = src; t.rw = rw; t.mr = mr; t.mw = mw;
    t.rd = rd; t.gnt = gnt; t.rv = rv; t.e_req = e_req; t.e_sel = e_sel; t.e_we = e_we;
    t.e_wa = e_wa; t.e_stall = e_stall; t.e_fault = e_fault;
    tbl.push_back(t);
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs 1 ns later.
  task automatic apply(input vec_t t);
    @(negedge clk);
    rst_i = t.rst; instr_valid_i = t.v; result_src_i = t.src; reg_write_i = t.rw;
    mem_read_i = t.mr; mem_write_i = t.mw; rd_i = t.rd;
    dmem_gnt_i = t.gnt; dmem_rvalid_i = t.rv;
    #1;
    n_vec++;
    if (dmem_req_o !== t.e_req || sel_o !== t.e_sel || rf_we_o !== t.e_we ||
        rf_waddr_o !== t.e_wa || stall_o !== t.e_stall || fault_o !== t.e_fault) begin
      n_err++;
      $display("FAIL %s: got req=%b sel=%b we=%b waddr=%0d stall=%b fault=%b, expected req=%b sel=%b we=%b waddr=%0d stall=%b fault=%b",
               t.name, dmem_req_o, sel_o, rf_we_o, rf_waddr_o, stall_o, fault_o,
               t.e_req, t.e_sel, t.e_we, t.e_wa, t.e_stall, t.e_fault);
    end
  endtask

  // Reference model: tracks the outstanding access as a phase
  // (0 none, 1 waiting for grant, 2 waiting for data) plus time spent in it.
  int         m_phase = 0;
  int         m_waited = 0;
  logic [4:0] m_rd = '0;
  bit         m_ld = 1'b0;

  task automatic model(inout vec_t t);
    t.e_req = 0; t.e_sel = 2'b00; t.e_we = 0; t.e_wa = 0; t.e_stall = 0; t.e_fault = 0;
    if (t.rst) begin
      m_phase = 0; m_waited = 0; m_rd = '0; m_ld = 0;
    end else if (m_phase == 0) begin
      if (t.v && (t.mr || t.mw)) begin
        t.e_req = 1; t.e_stall = 1; m_rd = t.rd; m_ld = t.mr;
        m_waited = 0;
        if (!t.gnt) m_phase = 1;
        else if (t.mr) m_phase = 2;
        else t.e_stall = 0;
      end else if (t.v) begin
        t.e_sel = t.src; t.e_wa = t.rd; t.e_we = t.rw && (t.rd != 0);
      end
    end else begin
      bit evt = (m_phase == 1) ? t.gnt : t.rv;
      t.e_req = (m_phase == 1); t.e_stall = 1;
      if (evt) begin
        if (m_phase == 1 && m_ld) begin
          m_phase = 2; m_waited = 0;
        end else begin
          t.e_stall = 0;
          if (m_phase == 2) begin
            t.e_sel = 2'b01; t.e_wa = m_rd; t.e_we = (m_rd != 0);
          end
          m_phase = 0;
        end
      end else if (TO_EN && m_waited == TO - 1) begin
        t.e_req = 0; t.e_stall = 0; t.e_fault = 1; m_phase = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  initial begin
    rst_i = 1; instr_valid_i = 0; result_src_i = 0; reg_write_i = 0;
    mem_read_i = 0; mem_write_i = 0; rd_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;

    //   name           rst v src   rw mr mw rd  g  r   req sel  we wa  st f
    add("reset",        1, 1, 2'b00, 1, 0, 0, 5, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add("add_x5",       0, 1, 2'b00, 1, 0, 0, 5, 0, 0,  0, 2'b00, 1, 5, 0, 0);
    add("jal_x0",       0, 1, 2'b10, 1, 0, 0, 0, 0, 0,  0, 2'b10, 0, 0, 0, 0);
    add("idle_noinstr", 0, 0, 2'b11, 1, 0, 0, 9, 1, 1,  0, 2'b00, 0, 0, 0, 0);
    add("lw_x7_req",    0, 1, 2'b01, 1, 1, 0, 7, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    add("lw_x7_wait1",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("lw_x7_wait2",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("lw_x7_wb",     0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 1, 7, 0, 0);
    add("sw_req",       0, 1, 2'b00, 0, 0, 1, 3, 0, 0,  1, 2'b00, 0, 0, 1, 0);
    add("sw_nogrant",   0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  1, 2'b00, 0, 0, 1, 0);
    add("sw_grant",     0, 0, 2'b00, 0, 0, 0, 0, 1, 0,  1, 2'b00, 0, 0, 0, 0);
    add("after_sw",     0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 0, 0);
    add("lw_x9_req",    0, 1, 2'b01, 1, 1, 0, 9, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    add("lw_x9_wait",   0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("rst_in_wait",  1, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0);
    add("late_rvalid",  0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0);
    add("pc4b_x31",     0, 1, 2'b11, 1, 0, 0,31, 0, 0,  0, 2'b11, 1,31, 0, 0);
    add("ldst_req",     0, 1, 2'b01, 1, 1, 1, 4, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    add("ldst_wb",      0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 1, 4, 0, 0);
    add("lw_x0_req",    0, 1, 2'b01, 1, 1, 0, 0, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    add("lw_x0_wb",     0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 0, 0, 0, 0);
    add("lw_x2_req",    0, 1, 2'b01, 1, 1, 0, 2, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    add("wait_ign_gnt", 0, 1, 2'b00, 1, 0, 0, 6, 1, 0,  0, 2'b00, 0, 0, 1, 0);
    add("lw_x2_wb",     0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 1, 2, 0, 0);
    add("sw_fast",      0, 1, 2'b00, 1, 0, 1, 8, 1, 0,  1, 2'b00, 0, 0, 0, 0);
    add("idle_rvalid",  0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();

`ifdef WBS_TIMEOUT_EN
    add("to_req",       0, 1, 2'b01, 1, 1, 0,12, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++)
      add("to_wait",    0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("to_fault",     0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 0, 1);
    add("to_idle_add",  0, 1, 2'b00, 1, 0, 0, 1, 0, 1,  0, 2'b00, 1, 1, 0, 0);
    add("to2_req",      0, 1, 2'b01, 1, 1, 0,13, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++)
      add("to2_wait",   0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("to2_evt_wins", 0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 1,13, 0, 0);
    add("to_sw_req",    0, 1, 2'b00, 0, 0, 1, 3, 0, 0,  1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++)
      add("to_sw_nognt",0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  1, 2'b00, 0, 0, 1, 0);
    add("to_sw_fault",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 0, 1);
    add("to_sw_idle",   0, 0, 2'b00, 0, 0, 0, 0, 1, 0,  0, 2'b00, 0, 0, 0, 0);
`else
    add("long_req",     0, 1, 2'b01, 1, 1, 0,14, 1, 0,  1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      add("long_wait",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, 1, 0);
    add("long_wb",      0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 2'b01, 1,14, 0, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Randomized run against the reference model, starting from reset.
    for (int i = 0; i < 3000; i++) begin
      vec_t t;
      int   kind;
      t.name = "random";
      t.rst  = (i == 0) || ($urandom_range(0, 40) == 0);
      t.v    = ($urandom_range(0, 3) != 0);
      t.src  = 2'($urandom_range(0, 3));
      t.rw   = 1'($urandom_range(0, 1));
      kind   = $urandom_range(0, 5);
      t.mr   = (kind == 0) || (kind == 2);
      t.mw   = (kind == 1) || (kind == 2);
      t.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      t.gnt  = ($urandom_range(0, 2) == 0);
      t.rv   = ($urandom_range(0, 3) == 0);
      model(t);
      apply(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Writeback sequencer for the RV32I core. It holds off retirement while a data-memory access is in flight, using a request/grant/rvalid handshake. It drives the select of the result mux, which chooses between ALU result, load data and PC+4, and it drives the register-file write enable and write address. Non-memory instructions still retire in one cycle. Loads and stores stall the core until memory completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: cycles without grant or rvalid before a bus fault is raised. Only used when WBS_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk_i, input, 1: single clock. All state changes on the rising edge.
- rst_i, input, 1: reset, synchronous and active-high.
- instr_valid_i, input, 1: decoded instruction present this cycle.
- result_src_i, input, 2: result source from the decoder. 00 = ALU, 01 = memory, 10/11 = PC+4.
- reg_write_i, input, 1: the instruction writes rd.
- mem_read_i, input, 1: the instruction is a load.
- mem_write_i, input, 1: the instruction is a store.
- rd_i, input, 5: destination register index.
- dmem_req_o, output, 1: data-memory request.
- dmem_gnt_i, input, 1: request accepted by memory.
- dmem_rvalid_i, input, 1: load data valid on the memory read bus.
- sel_o, output, 2: result-mux select.
- rf_we_o, output, 1: register-file write enable.
- rf_waddr_o, output, 5: register-file write address.
- stall_o, output, 1: hold PC and decode this cycle.
- fault_o, output, 1: one-cycle bus-timeout pulse. Tied to 0 when the timeout feature is compiled out.

## Operation
- The FSM has three states: IDLE, REQ and WAIT. Reset state is IDLE.
- While rst_i = 1, all outputs are 0 regardless of state. The state register becomes IDLE and the counter becomes 0 on the next edge.
- IDLE, non-memory instruction (instr_valid_i = 1, mem_read_i = 0, mem_write_i = 0):
  - sel_o = result_src_i, rf_waddr_o = rd_i.
  - rf_we_o = reg_write_i AND (rd_i != 0).
  - stall_o = 0. The instruction retires this cycle and the FSM stays in IDLE.
- IDLE, memory instruction:
  - dmem_req_o = 1, stall_o = 1, rf_we_o = 0.
  - rd_i and the load flag are latched into internal registers.
  - If dmem_gnt_i = 1 and it is a store: retire this cycle with stall_o = 0 and stay in IDLE.
  - If dmem_gnt_i = 1 and it is a load: go to WAIT.
  - Otherwise go to REQ.
- REQ: dmem_req_o = 1 and stall_o = 1.
  - A grant on a store retires it (stall_o = 0 that cycle) and returns to IDLE.
  - A grant on a load goes to WAIT.
- WAIT: dmem_req_o = 0 and stall_o = 1 while dmem_rvalid_i = 0. When dmem_rvalid_i = 1, in that same cycle:
  - sel_o = 01, rf_waddr_o = latched rd.
  - rf_we_o = 1 if the latched rd != 0.
  - stall_o = 0; the FSM returns to IDLE.
- dmem_rvalid_i outside WAIT is ignored. dmem_gnt_i outside IDLE/REQ is ignored.
- If mem_read_i and mem_write_i are both 1, the instruction is treated as a load.
- Outside the explicit cases above, sel_o = 00, rf_we_o = 0 and rf_waddr_o = 0.

## Timing
- Non-memory instruction: 0 extra cycles.
- Load with grant in the request cycle and rvalid N cycles later (N ≥ 1): the core is stalled for N cycles and writeback happens in the (N+1)th cycle.
- Store with grant in the request cycle: 0 stall cycles.
- All outputs are combinational from the state register and the current inputs. There are no registered outputs, so there is no added latency.
- A reset asserted mid-access (REQ or WAIT) drops the request immediately, because outputs are 0 while rst_i = 1. The in-flight access is abandoned; memory must tolerate a dropped request.

## Configuration
- Macro WBS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ or WAIT and increments every cycle spent in REQ/WAIT without the awaited event.
  - When the counter reaches TIMEOUT_CYCLES − 1 and the event is still absent: that cycle fault_o = 1, stall_o = 0, rf_we_o = 0 and dmem_req_o = 0. The FSM then returns to IDLE.
  - If the event and the timeout coincide, the event wins: normal completion, no fault.
- Undefined: no counter is built, fault_o = 0, and the FSM waits indefinitely.

## Structure
- Package wbs_pkg holds:
  - the result_src_e enum: RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_PC4B = 2'b11;
  - the wbs_state_e enum: IDLE, REQ, WAIT;
  - the parameter range check constants.
- Sub-module wbs_timeout_ctr (clear, enable, hit output), instantiated only under WBS_TIMEOUT_EN.
- The existing result mux stays a separate instance and is driven by sel_o.

## Test plan
- ADD x5 (result_src_i = 00, reg_write_i = 1, rd_i = 5), no memory access → same cycle sel_o = 00, rf_we_o = 1, rf_waddr_o = 5, stall_o = 0.
- JAL x0 (result_src_i = 10, rd_i = 0) → sel_o = 10, rf_we_o = 0.
- LW x7, grant in the request cycle, rvalid 3 cycles later → stall_o high for 3 cycles, then one cycle with sel_o = 01, rf_we_o = 1, rf_waddr_o = 7, stall_o = 0.
- SW with grant withheld for 2 cycles → dmem_req_o high for 3 cycles, stall_o high for 2 cycles, retire on the grant cycle, rf_we_o never asserted.
- LW with rst_i asserted in WAIT → all outputs 0 in that cycle, IDLE next cycle, a later rvalid is ignored.
- With WBS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, LW granted immediately and rvalid never arrives → fault_o pulses in the 4th WAIT cycle, no register write, IDLE next. Repeat with rvalid in exactly that cycle → normal writeback, fault_o = 0.
